// File: rtl/sdram_cmd_sequencer_if.sv
// sdram_cmd_sequencer_if: host request port and SDRAM pin bundle for sdram_cmd_sequencer.
interface sdram_cmd_sequencer_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [23:0] req_addr_i;
  logic [1:0]  req_mask_i;
  logic        rd_valid_o;
  logic        init_done_o;
  logic        sdram_clk_o;
  logic        sdram_cke_o;
  logic        sdram_cs_o;
  logic        sdram_ras_o;
  logic        sdram_cas_o;
  logic        sdram_we_o;
  logic [1:0]  sdram_dqm_o;
  logic [12:0] sdram_addr_o;
  logic [1:0]  sdram_ba_o;
  logic        sdram_data_out_en_o;
  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_mask_i,
    input  req_ready_o, rd_valid_o, init_done_o, sdram_clk_o, sdram_cke_o, sdram_cs_o,
           sdram_ras_o, sdram_cas_o, sdram_we_o, sdram_dqm_o, sdram_addr_o, sdram_ba_o,
           sdram_data_out_en_o
  );
  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_mask_i,
    output req_ready_o, rd_valid_o, init_done_o, sdram_clk_o, sdram_cke_o, sdram_cs_o,
           sdram_ras_o, sdram_cas_o, sdram_we_o, sdram_dqm_o, sdram_addr_o, sdram_ba_o,
           sdram_data_out_en_o
  );
endinterface

// File: rtl/sdram_cmd_sequencer.sv
// sdram_cmd_sequencer: SDRAM init, periodic refresh and single-word ACT->RD/WR with auto-precharge.
// Periodic refresh is built only when SDRAM_AUTO_REFRESH_EN is defined.
module sdram_cmd_sequencer #(
  parameter int INIT_CYCLES    = 10000,
  parameter int T_RP           = 2,
  parameter int T_RCD          = 2,
  parameter int T_RFC          = 7,
  parameter int T_MRD          = 2,
  parameter int T_WR           = 2,
  parameter int CAS_LAT        = 2,
  parameter int REFRESH_CYCLES = 780
) (
  input logic clk_i,
  input logic rst_i,
  sdram_cmd_sequencer_if.slave bus
);
  typedef enum logic [3:0] {INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS, IDLE, REF, ACT, RW} state_t;
  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000;
  localparam int TOT = INIT_CYCLES + T_RP + T_RFC + T_MRD + T_RCD + T_WR + CAS_LAT + 2;
  localparam int CW = $clog2(TOT);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, len;
  logic [3:0] cmd_q, cmd_d;
  logic [12:0] a_q, a_d;
  logic [1:0] ba_q, ba_d, dqm_q, dqm_d, mask_q;
  logic [10:0] addr_q;
  logic we_q, cke_q, oe_q, oe_d, rdv_q, rdv_d, init_done_q, last, enter, ready, accept, refresh_pending;
`ifdef SDRAM_AUTO_REFRESH_EN
  localparam int RCW = $clog2(REFRESH_CYCLES);
  logic [RCW-1:0] rcnt_q;
  logic pend_q, wrap;
  // a wrap is visible in the same cycle so a coincident request loses to refresh
  assign wrap = init_done_q && rcnt_q == RCW'(REFRESH_CYCLES - 1);
  assign refresh_pending = pend_q || wrap;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rcnt_q <= '0;
      pend_q <= 1'b0;
    end else begin
      rcnt_q <= (!init_done_q || wrap) ? '0 : rcnt_q + 1'b1;
      pend_q <= refresh_pending && state_q != IDLE;
    end
`else
  assign refresh_pending = 1'b0;
`endif
  assign ready  = state_q == IDLE && !refresh_pending;
  assign accept = ready && bus.req_valid_i;
  always_comb begin
    len = state_q == INIT_WAIT ? CW'(INIT_CYCLES + 1) :
          state_q == INIT_PRE ? CW'(T_RP) :
          (state_q == INIT_REF1 || state_q == INIT_REF2 || state_q == REF) ? CW'(T_RFC) :
          state_q == INIT_MRS ? CW'(T_MRD) :
          state_q == ACT ? CW'(T_RCD) :
          state_q == RW ? (we_q ? CW'(T_WR + T_RP) : CW'(CAS_LAT + T_RP)) : CW'(1);
    last = cnt_q == len - CW'(1);
    state_d = state_q;
    case (state_q)
      INIT_WAIT: state_d = last ? INIT_PRE : state_q;
      INIT_PRE:  state_d = last ? INIT_REF1 : state_q;
      INIT_REF1: state_d = last ? INIT_REF2 : state_q;
      INIT_REF2: state_d = last ? INIT_MRS : state_q;
      IDLE:      state_d = refresh_pending ? REF : accept ? ACT : IDLE;
      ACT:       state_d = last ? RW : state_q;
      default:   state_d = last ? IDLE : state_q;
    endcase
    enter = state_d != state_q;
    cnt_d = (enter || state_q == IDLE) ? '0 : cnt_q + 1'b1;
    // pins carry the command of the state being entered, so each command leads its wait
    cmd_d = !enter ? C_NOP :
            state_d == INIT_PRE ? C_PRE :
            (state_d == INIT_REF1 || state_d == INIT_REF2 || state_d == REF) ? C_REF :
            state_d == INIT_MRS ? C_MRS :
            state_d == ACT ? C_ACT :
            state_d == RW ? (we_q ? C_WR : C_RD) : C_NOP;
    a_d = !enter ? '0 :
          state_d == INIT_PRE ? 13'h400 :
          state_d == INIT_MRS ? 13'(CAS_LAT << 4) :
          state_d == ACT ? bus.req_addr_i[23:11] :
          state_d == RW ? {4'b0010, addr_q[8:0]} : '0;
    ba_d = (enter && state_d == ACT) ? bus.req_addr_i[10:9] :
           (enter && state_d == RW) ? addr_q[10:9] : '0;
    dqm_d = (enter && state_d == RW) ? (we_q ? ~mask_q : 2'b00) :
            (state_q == RW && !we_q && cnt_q < CW'(CAS_LAT)) ? 2'b00 : 2'b11;
    oe_d = enter && state_d == RW && we_q;
    rdv_d = state_q == RW && !we_q && cnt_q == CW'(CAS_LAT - 1);
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q     <= INIT_WAIT;
      cnt_q       <= '0;
      cmd_q       <= 4'b1111;
      a_q         <= '0;
      ba_q        <= '0;
      dqm_q       <= 2'b11;
      oe_q        <= 1'b0;
      rdv_q       <= 1'b0;
      cke_q       <= 1'b0;
      init_done_q <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      mask_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      a_q         <= a_d;
      ba_q        <= ba_d;
      dqm_q       <= dqm_d;
      oe_q        <= oe_d;
      rdv_q       <= rdv_d;
      cke_q       <= 1'b1;
      init_done_q <= init_done_q || state_d == IDLE;
      if (accept) begin
        addr_q <= bus.req_addr_i[10:0];
        we_q   <= bus.req_we_i;
        mask_q <= bus.req_mask_i;
      end
    end
  assign bus.req_ready_o = ready;
  assign bus.rd_valid_o = rdv_q;
  assign bus.init_done_o = init_done_q;
  assign bus.sdram_clk_o = ~clk_i;
  assign bus.sdram_cke_o = cke_q;
  assign {bus.sdram_cs_o, bus.sdram_ras_o, bus.sdram_cas_o, bus.sdram_we_o} = cmd_q;
  assign bus.sdram_dqm_o = dqm_q;
  assign bus.sdram_addr_o = a_q;
  assign bus.sdram_ba_o = ba_q;
  assign bus.sdram_data_out_en_o = oe_q;
endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// tb_sdram_cmd_sequencer: scoreboard bench; expected commands are queued by stimulus, checked by a pin monitor.
module tb_sdram_cmd_sequencer;
  localparam logic [3:0] C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000;
  typedef struct {
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] a;
    logic        chk_a;
    logic [1:0]  dqm;
    logic        oe;
    int          cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc, n_chk, n_fail, ref_seen, acc, r0;
  exp_t cq[$];
  int rq[$];
  logic [3:0] mc;
  exp_t me;
  always #5 clk = ~clk;
  sdram_cmd_sequencer_if bus ();
  sdram_cmd_sequencer #(
    .INIT_CYCLES(8), .T_RP(2), .T_RCD(2), .T_RFC(7), .T_MRD(2), .T_WR(2), .CAS_LAT(2), .REFRESH_CYCLES(64)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic push(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a, input logic ca,
                      input logic [1:0] dqm, input logic oe, input int at);
    exp_t e;
    e.cmd = c; e.ba = ba; e.a = a; e.chk_a = ca; e.dqm = dqm; e.oe = oe; e.cyc = at;
    cq.push_back(e);
  endtask
  always @(negedge clk)
    if (!rst) begin
      mc = {bus.sdram_cs_o, bus.sdram_ras_o, bus.sdram_cas_o, bus.sdram_we_o};
      if (!mc[3] && mc != 4'b0111) begin
        if (mc == C_REF) ref_seen++;
        if (cq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_cmd: got %b at cycle %0d, required no command", mc, cyc);
        end else begin
          me = cq.pop_front();
          chk("cmd", 32'(mc), 32'(me.cmd));
          chk("cmd_cycle", cyc, me.cyc);
          chk("ba", 32'(bus.sdram_ba_o), 32'(me.ba));
          if (me.chk_a) chk("addr", 32'(bus.sdram_addr_o), 32'(me.a));
          chk("dqm", 32'(bus.sdram_dqm_o), 32'(me.dqm));
          chk("data_out_en", 32'(bus.sdram_data_out_en_o), 32'(me.oe));
        end
      end else if (bus.sdram_data_out_en_o) begin
        n_chk++;
        n_fail++;
        $display("FAIL data_out_en_on_nop: got 1 at cycle %0d, required 0", cyc);
      end
      if (bus.rd_valid_o) begin
        if (rq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rd_valid: got 1 at cycle %0d, required 0", cyc);
        end else chk("rd_valid_cycle", cyc, rq.pop_front());
      end
    end
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic check_reset();
    chk("rst_cke", 32'(bus.sdram_cke_o), 0);
    chk("rst_cmd", 32'({bus.sdram_cs_o, bus.sdram_ras_o, bus.sdram_cas_o, bus.sdram_we_o}), 32'hF);
    chk("rst_dqm", 32'(bus.sdram_dqm_o), 3);
    chk("rst_addr", 32'(bus.sdram_addr_o), 0);
    chk("rst_ba", 32'(bus.sdram_ba_o), 0);
    chk("rst_oe", 32'(bus.sdram_data_out_en_o), 0);
    chk("rst_ready", 32'(bus.req_ready_o), 0);
    chk("rst_rd_valid", 32'(bus.rd_valid_o), 0);
    chk("rst_init_done", 32'(bus.init_done_o), 0);
  endtask
  // release happens at a negedge with cyc=0; edge n after release is cycle n
  task automatic push_init();
    push(C_PRE, 2'd0, 13'h400, 1'b1, 2'b11, 1'b0, 9);
    push(C_REF, 2'd0, 13'h000, 1'b0, 2'b11, 1'b0, 11);
    push(C_REF, 2'd0, 13'h000, 1'b0, 2'b11, 1'b0, 18);
    push(C_MRS, 2'd0, 13'h020, 1'b1, 2'b11, 1'b0, 25);
  endtask
  task automatic req(input logic we, input logic [23:0] addr, input logic [1:0] mask,
                     input logic [12:0] row_e, input logic [1:0] ba_e, input logic [12:0] col_e,
                     input logic [1:0] dqm_e, input bit abort, output int acc_o);
    int n;
    bus.req_valid_i = 1'b1;
    bus.req_we_i = we;
    bus.req_addr_i = addr;
    bus.req_mask_i = mask;
    n = 0;
    while (!bus.req_ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready_o) begin
      n_chk++;
      n_fail++;
      $display("FAIL req_ready_timeout: got ready=0 after %0d cycles, required 1", n);
    end
    acc_o = cyc + 1;
    push(C_ACT, ba_e, row_e, 1'b1, 2'b11, 1'b0, acc_o);
    if (!abort) begin
      push(we ? C_WR : C_RD, ba_e, col_e, 1'b1, dqm_e, we, acc_o + 2);
      if (!we) rq.push_back(acc_o + 4);
    end
    @(negedge clk);
    bus.req_valid_i = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_we_i = 1'b0;
    bus.req_addr_i = '0;
    bus.req_mask_i = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset();
    push_init();
    rst = 1'b0;
    @(negedge clk);
    chk("cke_after_reset", 32'(bus.sdram_cke_o), 1);
    chk("first_cmd_nop", 32'({bus.sdram_cs_o, bus.sdram_ras_o, bus.sdram_cas_o, bus.sdram_we_o}), 32'h7);
    wait_cyc(26);
    chk("init_done_before", 32'(bus.init_done_o), 0);
    @(negedge clk);
    chk("init_done", 32'(bus.init_done_o), 1);
    chk("ready_after_init", 32'(bus.req_ready_o), 1);
    req(1'b1, {13'd5, 2'd1, 9'h1F3}, 2'b01, 13'd5, 2'd1, 13'h5F3, 2'b10, 1'b0, acc);
    chk("write_accept_cycle", acc, 28);
    req(1'b0, {13'd5, 2'd1, 9'h1F3}, 2'b11, 13'd5, 2'd1, 13'h5F3, 2'b00, 1'b0, acc);
    chk("read_accept_cycle", acc, 35);
    for (int k = 0; k < 6; k++) begin
      chk("ready_low_in_read", 32'(bus.req_ready_o), 0);
      if (k >= 2 && k <= 4) chk("read_dqm_open", 32'(bus.sdram_dqm_o), 0);
      if (k == 5) chk("read_dqm_closed", 32'(bus.sdram_dqm_o), 3);
      @(negedge clk);
    end
    chk("ready_after_read", 32'(bus.req_ready_o), 1);
`ifdef SDRAM_AUTO_REFRESH_EN
    wait_cyc(90);
    push(C_REF, 2'd0, 13'h000, 1'b0, 2'b11, 1'b0, 91);
    req(1'b1, {13'h1ABC, 2'd3, 9'h0A5}, 2'b10, 13'h1ABC, 2'd3, 13'h4A5, 2'b01, 1'b0, acc);
    chk("accept_after_refresh", acc, 99);
`else
    r0 = ref_seen;
    repeat (500) @(negedge clk);
    chk("no_refresh_in_idle", ref_seen - r0, 0);
    chk("ready_idle_long", 32'(bus.req_ready_o), 1);
`endif
    req(1'b0, {13'h0777, 2'd2, 9'h100}, 2'b00, 13'h0777, 2'd2, 13'h000, 2'b00, 1'b1, acc);
    #2 rst = 1'b1;
    #1 check_reset();
    chk("abort_cmd_queue", cq.size(), 0);
    chk("abort_rd_queue", rq.size(), 0);
    repeat (2) @(negedge clk);
    check_reset();
    push_init();
    rst = 1'b0;
    wait_cyc(27);
    chk("reinit_done", 32'(bus.init_done_o), 1);
    chk("reinit_ready", 32'(bus.req_ready_o), 1);
    repeat (3) @(negedge clk);
    chk("cmd_queue_drained", cq.size(), 0);
    chk("rd_queue_drained", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
